// File: rtl/ws2811_rx.sv
// ws2811_rx: single-wire WS2811/WS2812 pixel stream decoder.
// Classifies high-pulse widths into bits, assembles GRB pixels, and flags frame ends and line errors.
module ws2811_rx #(
  parameter int THRESH_CYCLES   = 29,
  parameter int MIN_HIGH_CYCLES = 5,
  parameter int MAX_HIGH_CYCLES = 96,
  parameter int RESET_CYCLES    = 2400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] address,
  output logic       pixel_valid,
  output logic       frame_done,
  output logic       bit_error,
  output logic [1:0] dbg_state
);

  // Output semantics: pixel_valid, frame_done and bit_error are single-cycle strobes with no
  // backpressure; red/green/blue/address are valid while pixel_valid is high and hold until the next one.

  typedef enum logic [1:0] {S_GAP, S_ARMED, S_HIGH, S_LOW} state_t;

  localparam logic [11:0] C_THRESH   = 12'(THRESH_CYCLES);
  localparam logic [11:0] C_MIN      = 12'(MIN_HIGH_CYCLES);
  localparam logic [11:0] C_MAX_M1   = 12'(MAX_HIGH_CYCLES - 1);
  localparam logic [11:0] C_RESET_M1 = 12'(RESET_CYCLES - 1);
  localparam logic [11:0] C_SAT      = 12'hFFF;
  localparam logic [8:0]  C_PMAX     = 9'd256;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_din_s;
  logic        r_line;
  logic        r_rise;
  logic        r_fall;
  logic [11:0] r_hcnt;
  logic [11:0] r_lcnt;
  logic [23:0] r_shift;
  logic [4:0]  r_bcnt;
  logic [8:0]  r_pcnt;

  logic        w_bit;
  logic [23:0] w_shift_next;
  logic        w_gap_done;
  logic        w_hmax;
  logic        w_short;
  logic        w_shift_en;
  logic        w_frame_end;
  logic        w_err;
  logic        w_pix_done;
  logic        w_pix_strobe;
  logic        w_frame_done;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == C_SAT) ? v : v + 12'd1;
  endfunction

  // r_line is din_s delayed one cycle so the registered edge flags line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_din_s <= 1'b0;
      r_line  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_din_s <= r_sync1;
      r_line  <= r_din_s;
      r_rise  <= r_din_s & ~r_line;
      r_fall  <= ~r_din_s & r_line;
    end
  end

  assign w_bit        = (r_hcnt >= C_THRESH);
  assign w_shift_next = {r_shift[22:0], w_bit};
  assign w_gap_done   = (r_lcnt >= C_RESET_M1);
  assign w_hmax       = (r_hcnt >= C_MAX_M1);
  assign w_short      = (r_hcnt < C_MIN);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_GAP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GAP:   if (!r_line && w_gap_done) w_next = S_ARMED;
      S_ARMED: if (r_rise) w_next = S_HIGH;
      S_HIGH: begin
        if (r_fall)      w_next = w_short ? S_GAP : S_LOW;
        else if (w_hmax) w_next = S_GAP;
      end
      S_LOW: begin
        if (r_rise)          w_next = S_HIGH;
        else if (w_gap_done) w_next = S_ARMED;
      end
      default: w_next = S_GAP;
    endcase
  end

  always_comb begin
    w_shift_en  = 1'b0;
    w_frame_end = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_HIGH: begin
        if (r_fall) begin
          if (w_short) w_err      = 1'b1;
          else         w_shift_en = 1'b1;
        end else if (w_hmax) begin
          w_err = 1'b1;
        end
      end
      S_LOW: begin
        if (!r_rise && w_gap_done) begin
          w_frame_end = 1'b1;
          w_err       = (r_bcnt != 5'd0);
        end
      end
      default: ;
    endcase
  end

  assign w_pix_done   = w_shift_en && (r_bcnt == 5'd23);
  assign w_pix_strobe = w_pix_done && (r_pcnt != C_PMAX);
  assign w_frame_done = w_frame_end && (r_pcnt != 9'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt  <= 12'd0;
      r_lcnt  <= 12'd0;
      r_shift <= 24'd0;
      r_bcnt  <= 5'd0;
      r_pcnt  <= 9'd0;
    end else begin
      case (r_state)
        S_GAP: begin
          r_hcnt <= 12'd0;
          r_lcnt <= r_line ? 12'd0 : sat_inc(r_lcnt);
          r_bcnt <= 5'd0;
          r_pcnt <= 9'd0;
        end
        S_ARMED: begin
          r_lcnt <= 12'd0;
          if (r_rise) r_hcnt <= 12'd1;
        end
        S_HIGH: begin
          r_hcnt <= sat_inc(r_hcnt);
          if (r_fall)      r_lcnt <= w_short ? 12'd0 : 12'd1;
          else if (w_hmax) r_lcnt <= 12'd0;
          if (w_shift_en) begin
            r_shift <= w_shift_next;
            r_bcnt  <= w_pix_done ? 5'd0 : r_bcnt + 5'd1;
            if (w_pix_strobe) r_pcnt <= r_pcnt + 9'd1;
          end
        end
        S_LOW: begin
          r_lcnt <= sat_inc(r_lcnt);
          if (r_rise) r_hcnt <= 12'd1;
          if (w_frame_end) begin
            r_bcnt <= 5'd0;
            r_pcnt <= 9'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      address     <= 8'd0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      pixel_valid <= w_pix_strobe;
      frame_done  <= w_frame_done;
      bit_error   <= w_err;
      if (w_pix_strobe) begin
        green   <= w_shift_next[23:16];
        red     <= w_shift_next[15:8];
        blue    <= w_shift_next[7:0];
        address <= r_pcnt[7:0];
      end
    end
  end

  assign dbg_state = r_state;

endmodule
